// File: rtl/uart_word_packer_pkg.sv
// Shared constants for the UART word path: assembly FSM encoding, word geometry
// and the default inter-byte timeout.
package uart_word_packer_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } asm_state_t;

    localparam int BYTES_PER_WORD         = 4;
    localparam int TIMEOUT_CYCLES_DEFAULT = 50000;

    function automatic logic is_last_byte(input logic [1:0] cnt);
        return cnt == 2'(BYTES_PER_WORD - 1);
    endfunction

endpackage

// File: rtl/uart_word_packer_if.sv
// Byte-in / word-out handshake bundle of the UART word packer.
interface uart_word_packer_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;

    modport master (
        output rx_data, rx_valid, word_ready,
        input  word_out, word_valid
    );

    modport slave (
        input  rx_data, rx_valid, word_ready,
        output word_out, word_valid
    );
endinterface

// File: rtl/uart_byte_timeout.sv
// Inter-byte idle counter: counts enabled cycles since the last clear and
// pulses expire on the cycle it would pass TIMEOUT_CYCLES-1.
module uart_byte_timeout #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TMO_W          = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] count;

    // A clear in the expiry cycle wins, so a byte arriving just in time is kept.
    assign expire = enable && !clear && (count == LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_word_packer.sv
// Packs four UART bytes, LSB first, into a 32-bit word behind a one-word
// valid/ready output register, with inter-byte timeout and sticky error flags.
module uart_word_packer
    import uart_word_packer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int TMO_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    uart_word_packer_if.slave bus,
    output logic [1:0]        byte_cnt,
    output logic              overrun,
    output logic              timeout_err,
    input  logic              clr_err
);

    asm_state_t  state, state_next;
    logic [23:0] assembly;
    logic [31:0] word_q;
    logic        word_valid_q;
    logic        store_byte, complete, timer_clear, timer_enable, expire, load_ok;

    uart_byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TMO_W         (TMO_W)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .enable(timer_enable),
        .expire(expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.rx_valid) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.rx_valid && is_last_byte(byte_cnt)) begin
                    state_next = IDLE;
                end else if (expire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The timer is held cleared in IDLE so there is never a timeout between words.
    always_comb begin
        store_byte   = 1'b0;
        complete     = 1'b0;
        timer_clear  = 1'b1;
        timer_enable = 1'b0;
        case (state)
            IDLE: begin
                store_byte = bus.rx_valid;
            end
            COLLECT: begin
                timer_enable = 1'b1;
                timer_clear  = bus.rx_valid;
                store_byte   = bus.rx_valid && !is_last_byte(byte_cnt);
                complete     = bus.rx_valid && is_last_byte(byte_cnt);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            assembly <= '0;
            byte_cnt <= '0;
        end else if (expire) begin
            assembly <= '0;
            byte_cnt <= '0;
        end else if (complete) begin
            byte_cnt <= '0;
        end else if (store_byte) begin
            case (byte_cnt)
                2'd0:    assembly[7:0]   <= bus.rx_data;
                2'd1:    assembly[15:8]  <= bus.rx_data;
                2'd2:    assembly[23:16] <= bus.rx_data;
                default: ;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // A held word may be consumed and replaced on the same edge.
    assign load_ok = !word_valid_q || bus.word_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else if (complete && load_ok) begin
            word_q       <= {bus.rx_data, assembly};
            word_valid_q <= 1'b1;
        end else if (word_valid_q && bus.word_ready) begin
            word_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (complete && !load_ok) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (expire) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = word_valid_q;

endmodule

// File: tb/tb_uart_word_packer.sv
// Scoreboard bench for uart_word_packer: directed scenarios plus random byte
// streams checked against a queue-based reference model.
module tb_uart_word_packer;

    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr_err;
    logic [1:0] byte_cnt;
    logic       overrun;
    logic       timeout_err;

    uart_word_packer_if bus_if ();

    uart_word_packer #(
        .TIMEOUT_CYCLES(TMO),
        .TMO_W         (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_if),
        .byte_cnt   (byte_cnt),
        .overrun    (overrun),
        .timeout_err(timeout_err),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    int          n_tests  = 0;
    int          n_failed = 0;
    string       phase    = "init";

    logic [7:0]  m_bytes[$];
    logic [31:0] exp_words[$];
    int          m_idle;
    bit          m_full;
    logic [31:0] m_word;
    bit          m_ovr;
    bit          m_tmo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s/%s: got 0x%0h, expected 0x%0h at %0t", phase, name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_bytes.delete();
        exp_words.delete();
        m_idle = 0;
        m_full = 1'b0;
        m_word = '0;
        m_ovr  = 1'b0;
        m_tmo  = 1'b0;
    endtask

    // Model of one clock cycle at the level of "bytes in a partial word" and
    // "is the output slot occupied".
    task automatic modelStep(input bit rxv, input logic [7:0] d, input bit rdy, input bit clr);
        bit          loaded = 1'b0;
        bit          ev_ovr = 1'b0;
        bit          ev_tmo = 1'b0;
        logic [31:0] w;
        if (rxv) begin
            m_bytes.push_back(d);
            m_idle = 0;
            if (m_bytes.size() == 4) begin
                w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                m_bytes.delete();
                if (!m_full || rdy) begin
                    loaded = 1'b1;
                    m_word = w;
                    exp_words.push_back(w);
                end else begin
                    ev_ovr = 1'b1;
                end
            end
        end else if (m_bytes.size() != 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_bytes.delete();
                m_idle = 0;
                ev_tmo = 1'b1;
            end
        end
        if (loaded)    m_full = 1'b1;
        else if (rdy)  m_full = 1'b0;
        if (ev_ovr)    m_ovr = 1'b1;
        else if (clr)  m_ovr = 1'b0;
        if (ev_tmo)    m_tmo = 1'b1;
        else if (clr)  m_tmo = 1'b0;
    endtask

    task automatic checkOutput();
        check("byte_cnt",    32'(byte_cnt),           32'(m_bytes.size()));
        check("word_valid",  32'(bus_if.word_valid),  32'(m_full));
        check("word_out",    bus_if.word_out,         m_word);
        check("overrun",     32'(overrun),            32'(m_ovr));
        check("timeout_err", 32'(timeout_err),        32'(m_tmo));
    endtask

    task automatic applyStimulus(input bit rxv, input logic [7:0] d, input bit rdy, input bit clr);
        bus_if.rx_valid   = rxv;
        bus_if.rx_data    = d;
        bus_if.word_ready = rdy;
        clr_err           = clr;
        modelStep(rxv, d, rdy, clr);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic sendByte(input logic [7:0] d, input bit rdy);
        applyStimulus(1'b1, d, rdy, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, rdy, 1'b0);
    endtask

    task automatic pulseReset();
        bus_if.rx_valid   = 1'b0;
        bus_if.word_ready = 1'b0;
        clr_err           = 1'b0;
        reset             = 1'b0;
        #2;
        modelReset();
        checkOutput();
        @(posedge clk);
        #1;
        checkOutput();
        reset = 1'b1;
    endtask

    // Whenever a handshake is about to complete, the held word must be the
    // oldest word the model says was accepted into the output register.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus_if.word_valid === 1'b1 && bus_if.word_ready === 1'b1) begin
            if (exp_words.size() == 0) begin
                check("unexpected_word", bus_if.word_out, 32'hFFFF_FFFF ^ bus_if.word_out);
            end else begin
                check("handshake_word", bus_if.word_out, exp_words.pop_front());
            end
        end
    end

    initial begin
        int gap;
        reset             = 1'b0;
        clr_err           = 1'b0;
        bus_if.rx_valid   = 1'b0;
        bus_if.rx_data    = 8'h00;
        bus_if.word_ready = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        phase = "reset";
        checkOutput();
        reset = 1'b1;

        phase = "basic";
        sendByte(8'h11, 1'b1); idle(10, 1'b1);
        sendByte(8'h22, 1'b1); idle(10, 1'b1);
        sendByte(8'h33, 1'b1); idle(10, 1'b1);
        sendByte(8'h44, 1'b1);
        check("basic_word", bus_if.word_out, 32'h4433_2211);
        idle(3, 1'b1);

        phase = "overrun";
        sendByte(8'hDD, 1'b0); sendByte(8'hCC, 1'b0);
        sendByte(8'hBB, 1'b0); sendByte(8'hAA, 1'b0);
        sendByte(8'h04, 1'b0); sendByte(8'h03, 1'b0);
        sendByte(8'h02, 1'b0); sendByte(8'h01, 1'b0);
        check("overrun_hold", bus_if.word_out, 32'hAABB_CCDD);
        check("overrun_flag", 32'(overrun), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        check("overrun_cleared", 32'(overrun), 32'd0);

        phase = "timeout";
        sendByte(8'h5A, 1'b1); sendByte(8'hA5, 1'b1);
        idle(TMO, 1'b1);
        check("timeout_flag", 32'(timeout_err), 32'd1);
        sendByte(8'h01, 1'b1); sendByte(8'h02, 1'b1);
        sendByte(8'h03, 1'b1); sendByte(8'h04, 1'b1);
        check("after_timeout_word", bus_if.word_out, 32'h0403_0201);
        idle(2, 1'b1);

        phase = "expiry_edge";
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        sendByte(8'h10, 1'b1);
        idle(TMO - 1, 1'b1);
        sendByte(8'h20, 1'b1);
        check("edge_no_timeout", 32'(timeout_err), 32'd0);
        check("edge_byte_cnt", 32'(byte_cnt), 32'd2);
        sendByte(8'h30, 1'b1); sendByte(8'h40, 1'b1);
        idle(2, 1'b1);

        phase = "mid_reset";
        sendByte(8'hE1, 1'b0); sendByte(8'hE2, 1'b0); sendByte(8'hE3, 1'b0);
        pulseReset();
        sendByte(8'hC1, 1'b1); sendByte(8'hC2, 1'b1);
        sendByte(8'hC3, 1'b1); sendByte(8'hC4, 1'b1);
        check("post_reset_word", bus_if.word_out, 32'hC4C3_C2C1);
        idle(2, 1'b1);

        phase = "back_to_back";
        sendByte(8'hA1, 1'b0); sendByte(8'hA2, 1'b0);
        sendByte(8'hA3, 1'b0); sendByte(8'hA4, 1'b0);
        sendByte(8'hB1, 1'b0); sendByte(8'hB2, 1'b0);
        sendByte(8'hB3, 1'b0); sendByte(8'hB4, 1'b1);
        check("b2b_valid", 32'(bus_if.word_valid), 32'd1);
        check("b2b_word", bus_if.word_out, 32'hB4B3_B2B1);
        check("b2b_overrun", 32'(overrun), 32'd0);
        idle(2, 1'b1);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TMO - 2, TMO + 1))
                                              : int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                applyStimulus(1'b0, 8'h00, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
            end
            applyStimulus(1'b1, 8'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
        end

        phase = "drain";
        idle(TMO + 2, 1'b1);
        check("scoreboard_empty", 32'(exp_words.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
